pci_arbiter: RTL

Central PCI bus arbiter for the DeviceA/B/C bus segment. Samples each device's active-low REQ, drives exactly one active-low GNT by round-robin, tracks bus ownership via FRAME/IRDY, and inserts a one-clock turnaround between owners. A latency timer revokes a grant when the granted master does not start a transaction.

---
 rtl/pci_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/pci_arbiter.sv
// Central round-robin PCI bus arbiter: active-low REQ/GNT, FRAME/IRDY ownership
// tracking, one-clock turnaround between owners and a grant latency timeout.
module pci_arbiter #(
  parameter int N_DEV       = 3,
  parameter int IDX_W       = 2,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] REQ,
  output logic [N_DEV-1:0] GNT,
  input  logic             FRAME,
  input  logic             IRDY,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             bus_busy
);

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, GAP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_nxt;
  logic [7:0]       timer, timer_nxt;
  logic [N_DEV-1:0] gnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt;
  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;

  // Comparisons against 1'b0 make X/Z request bits fall into the not-requesting path.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 0; off < N_DEV; off++) begin
      cand = IDX_W'((int'(rr_ptr) + off) % N_DEV);
      if (!found && (REQ[cand] == 1'b0)) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    timer_nxt = timer;
    gnt_nxt   = GNT;
    idx_nxt   = gnt_idx;
    valid_nxt = gnt_valid;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt         = '1;
          gnt_nxt[winner] = 1'b0;
          idx_nxt         = winner;
          valid_nxt       = 1'b1;
          timer_nxt       = 8'd0;
          state_nxt       = GRANTED;
        end
      end
      GRANTED: begin
        if (timer != 8'hFF) timer_nxt = timer + 8'd1;
        if (FRAME == 1'b0) begin
          state_nxt = BUSY;
        end else if ((REQ[gnt_idx] == 1'b0) && (timer != 8'(GNT_TIMEOUT - 1))) begin
          state_nxt = GRANTED;
        end else begin
          gnt_nxt   = '1;
          valid_nxt = 1'b0;
          idx_nxt   = '0;
          rr_nxt    = IDX_W'((int'(gnt_idx) + 1) % N_DEV);
          state_nxt = GAP;
        end
      end
      BUSY: begin
        if ((FRAME == 1'b1) && (IRDY == 1'b1)) begin
          gnt_nxt   = '1;
          valid_nxt = 1'b0;
          idx_nxt   = '0;
          rr_nxt    = IDX_W'((int'(gnt_idx) + 1) % N_DEV);
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      timer     <= 8'd0;
      GNT       <= '1;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      timer     <= timer_nxt;
      GNT       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      bus_busy  <= (state_nxt == BUSY);
    end
  end

endmodule
